// File: rtl/decode_scan_seq.sv
// decode_scan_seq
// Channel scan sequencer feeding the 3-bit select (A2,A1,A0) of a 3-to-8
// one-hot decoder. It walks the enabled channels in ascending or descending
// order, holds each one for a dwell period, and inserts blanking gaps so the
// downstream drivers never see overlapping selects.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       one-cycle pulse, begins a scan (IDLE only, mask != 0)
//   stop        one-cycle pulse, aborts the scan; wins over start
//   mode_sweep  1 = single sweep, 0 = continuous (latched at start)
//   dir         0 = ascending, 1 = descending (latched at start)
//   mask        per-channel enables (latched at start)
//   dwell       cycles per channel, 0 behaves as 1 (latched at start)
//   A2,A1,A0    channel select, A2 = MSB
//   addr_valid  high while the select is being held in DWELL
//   busy        high whenever not IDLE
//   ch_step     pulse on the first DWELL cycle of every channel
//   sweep_done  pulse on the final cycle of the last channel of a sweep
module decode_scan_seq #(
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_sweep,
  input  logic               dir,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               A2,
  output logic               A1,
  output logic               A0,
  output logic               addr_valid,
  output logic               busy,
  output logic               ch_step,
  output logic               sweep_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_BLANK} state_t;

  localparam logic [DWELL_W-1:0] ONE      = DWELL_W'(1);
  localparam logic [DWELL_W-1:0] BLANK_LD = DWELL_W'(BLANK_CYC);

  // First enabled channel in scan order: lowest set bit when ascending,
  // highest when descending. The loop keeps the last hit, so iteration order
  // is reversed relative to scan order.
  function automatic logic [2:0] f_first(input logic [7:0] m, input logic d);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (d ? m[i] : m[7-i]) c = d ? 3'(i) : 3'(7 - i);
    end
    return c;
  endfunction

  // The last channel of a sweep is the first channel of the opposite order.
  function automatic logic [2:0] f_last(input logic [7:0] m, input logic d);
    return f_first(m, ~d);
  endfunction

  // Next enabled channel after cur, wrapping mod 8. Offsets are scanned
  // largest first so the nearest hit wins; with no other channel enabled the
  // result is cur itself, which gives the repeat-one-channel behaviour.
  function automatic logic [2:0] f_next(input logic [7:0] m, input logic d,
                                        input logic [2:0] cur);
    logic [2:0] c;
    logic [2:0] k;
    c = cur;
    for (int i = 7; i >= 1; i--) begin
      k = d ? (cur - 3'(i)) : (cur + 3'(i));
      if (m[k]) c = k;
    end
    return c;
  endfunction

  state_t             r_state, w_nstate;
  logic [DWELL_W-1:0] r_cnt, w_ncnt;
  logic [DWELL_W-1:0] r_dwell, w_ndwell;
  logic [2:0]         r_ch, w_nch;
  logic [7:0]         r_mask, w_nmask;
  logic               r_dir, w_ndir;
  logic               r_single, w_nsingle;
  logic               r_addr_valid, r_busy, r_ch_step, r_sweep_done;
  logic               w_entry;   // entering DWELL on a (new) channel
  logic               w_pend;    // current cycle closes a channel period
  logic               w_nfinal;  // next cycle closes the last channel's period

  always_comb begin
    w_nstate  = r_state;
    w_ncnt    = r_cnt;
    w_nch     = r_ch;
    w_nmask   = r_mask;
    w_ndir    = r_dir;
    w_nsingle = r_single;
    w_ndwell  = r_dwell;
    w_entry   = 1'b0;
    w_pend    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start && !stop && (mask != 8'h00)) begin
          w_nmask   = mask;
          w_ndir    = dir;
          w_nsingle = mode_sweep;
          w_ndwell  = (dwell == '0) ? ONE : dwell;
          w_nstate  = ST_DWELL;
          w_nch     = f_first(mask, dir);
          w_ncnt    = w_ndwell;
          w_entry   = 1'b1;
        end
      end
      ST_DWELL: begin
        if (r_cnt > ONE) begin
          w_ncnt = r_cnt - ONE;
        end else if (BLANK_CYC != 0) begin
          w_nstate = ST_BLANK;
          w_ncnt   = BLANK_LD;
        end else begin
          w_pend = 1'b1;
        end
      end
      ST_BLANK: begin
        if (r_cnt > ONE) w_ncnt = r_cnt - ONE;
        else             w_pend = 1'b1;
      end
      default: begin
        w_nstate = ST_IDLE;
        w_nch    = 3'd0;
        w_ncnt   = '0;
      end
    endcase

    if (w_pend) begin
      if (r_single && (r_ch == f_last(r_mask, r_dir))) begin
        w_nstate = ST_IDLE;
        w_nch    = 3'd0;
        w_ncnt   = '0;
      end else begin
        w_nstate = ST_DWELL;
        w_nch    = f_next(r_mask, r_dir, r_ch);
        w_ncnt   = r_dwell;
        w_entry  = 1'b1;
      end
    end

    if (stop && (r_state != ST_IDLE)) begin
      w_nstate = ST_IDLE;
      w_nch    = 3'd0;
      w_ncnt   = '0;
      w_entry  = 1'b0;
    end

    // Outputs are registered, so sweep_done is decided one cycle ahead from
    // the next-state values.
    w_nfinal = (w_nch == f_last(w_nmask, w_ndir)) && (w_ncnt == ONE) &&
               ((w_nstate == ST_BLANK) ||
                ((w_nstate == ST_DWELL) && (BLANK_CYC == 0)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_dwell      <= '0;
      r_ch         <= 3'd0;
      r_mask       <= 8'h00;
      r_dir        <= 1'b0;
      r_single     <= 1'b0;
      r_addr_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_ch_step    <= 1'b0;
      r_sweep_done <= 1'b0;
    end else begin
      r_state      <= w_nstate;
      r_cnt        <= w_ncnt;
      r_dwell      <= w_ndwell;
      r_ch         <= w_nch;
      r_mask       <= w_nmask;
      r_dir        <= w_ndir;
      r_single     <= w_nsingle;
      r_addr_valid <= (w_nstate == ST_DWELL);
      r_busy       <= (w_nstate != ST_IDLE);
      r_ch_step    <= w_entry;
      r_sweep_done <= w_nfinal;
    end
  end

  assign {A2, A1, A0} = r_ch;
  assign addr_valid   = r_addr_valid;
  assign busy         = r_busy;
  assign ch_step      = r_ch_step;
  assign sweep_done   = r_sweep_done;

endmodule

// File: tb/tb_decode_scan_seq.sv
module tb_decode_scan_seq;
  localparam int DW = 16;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1, start = 1'b0, stop = 1'b0, mode_sweep = 1'b0, dir = 1'b0;
  logic [7:0]    mask = 8'h00;
  logic [DW-1:0] dwell = '0;
  logic          A2, A1, A0, addr_valid, busy, ch_step, sweep_done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic [2:0] sel;
    logic       av;
    logic       bz;
    logic       st;
    logic       dn;
  } exp_t;

  // Model: the expected output of every future cycle of the scan, one entry
  // per cycle. Empty queue means IDLE.
  exp_t       q[$];
  logic [7:0] m_mask;
  logic       m_dir, m_single;
  int         m_dwell;

  decode_scan_seq #(.DWELL_W(DW), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_sweep(mode_sweep),
    .dir(dir), .mask(mask), .dwell(dwell), .A2(A2), .A1(A1), .A0(A0),
    .addr_valid(addr_valid), .busy(busy), .ch_step(ch_step), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Append one full sweep: each enabled channel in scan order gets
  // max(dwell,1) valid cycles then BC blank cycles; the sweep's last cycle
  // carries sweep_done.
  task automatic push_sweep(input logic [7:0] m, input logic d, input int dw);
    int   d_eff;
    exp_t e;
    logic [2:0] c;
    d_eff = (dw == 0) ? 1 : dw;
    for (int i = 0; i < 8; i++) begin
      c = d ? 3'(7 - i) : 3'(i);
      if (m[c]) begin
        for (int j = 0; j < d_eff; j++) begin
          e.sel = c; e.av = 1'b1; e.bz = 1'b1; e.st = (j == 0); e.dn = 1'b0;
          q.push_back(e);
        end
        for (int j = 0; j < BC; j++) begin
          e.sel = c; e.av = 1'b0; e.bz = 1'b1; e.st = 1'b0; e.dn = 1'b0;
          q.push_back(e);
        end
      end
    end
    e = q.pop_back();
    e.dn = 1'b1;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else if (q.size() != 0) begin
      if (stop) q.delete();
      else begin
        void'(q.pop_front());
        if (q.size() == 0 && !m_single) push_sweep(m_mask, m_dir, m_dwell);
      end
    end else if (start && !stop && mask != 8'h00) begin
      m_mask   <= mask;
      m_dir    <= dir;
      m_single <= mode_sweep;
      m_dwell  <= int'(dwell);
      push_sweep(mask, dir, int'(dwell));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e, a;
      e = (q.size() != 0) ? q[0] : '0;
      a = {A2, A1, A0, addr_valid, busy, ch_step, sweep_done};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle %0d sel/av/busy/step/done got %b want %b", cyc, a, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic do_start(input logic [7:0] m, input logic d, input logic sw, input int dw);
    mask = m; dir = d; mode_sweep = sw; dwell = DW'(dw); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  function automatic int sel();
    return int'({A2, A1, A0});
  endfunction

  initial begin
    int k_done, k_idle, steps, n_av, n_dn, first_dn, guard;
    int exp_seq[6];
    exp_seq = '{7, 4, 1, 7, 4, 1};

    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_outputs", int'({A2, A1, A0, addr_valid, busy, ch_step, sweep_done}), 0);
    tick();

    // Single ascending sweep, all channels, dwell 3.
    do_start(8'hFF, 1'b0, 1'b1, 3);
    k_done = -1; k_idle = -1; steps = 0;
    for (int k = 1; k <= 45; k++) begin
      if (sweep_done && k_done < 0) k_done = k;
      if (!busy && k_idle < 0) k_idle = k;
      if (ch_step) begin
        chk("t1_step_sel", sel(), steps);
        steps++;
      end
      tick();
    end
    chk("t1_done_cycle", k_done, 40);
    chk("t1_busy_fall", k_idle, 41);
    chk("t1_steps", steps, 8);

    // Descending continuous over 0x92, dwell 1.
    do_start(8'h92, 1'b1, 1'b0, 1);
    steps = 0; n_dn = 0;
    for (int k = 1; k <= 18; k++) begin
      if (ch_step && steps < 6) begin
        chk("t2_seq", sel(), exp_seq[steps]);
        steps++;
      end
      if (sweep_done) begin
        n_dn++;
        chk("t2_done_ch", sel(), 1);
        chk("t2_done_blank", int'(addr_valid), 0);
      end
      tick();
    end
    chk("t2_steps", steps, 6);
    chk("t2_dones", n_dn, 2);
    do_stop();
    chk("t2_stop_busy", int'(busy), 0);

    // Single channel 3, dwell 0, continuous.
    do_start(8'h08, 1'b0, 1'b0, 0);
    n_av = 0; n_dn = 0; first_dn = -1;
    for (int k = 1; k <= 12; k++) begin
      chk("t3_sel", sel(), 3);
      if (addr_valid) n_av++;
      if (sweep_done) begin
        n_dn++;
        if (first_dn < 0) first_dn = k;
      end
      tick();
    end
    chk("t3_av_count", n_av, 4);
    chk("t3_done_count", n_dn, 4);
    chk("t3_first_done", first_dn, 3);
    do_stop();

    // stop together with start on the second DWELL cycle of channel 2.
    do_start(8'hFF, 1'b0, 1'b0, 3);
    guard = 0;
    while (!(sel() == 2 && addr_valid && !ch_step) && guard < 60) begin
      tick();
      guard++;
    end
    chk("t4_reach_ch2", int'(guard < 60), 1);
    stop = 1'b1; start = 1'b1; dir = 1'b1; mask = 8'h01;
    tick();
    stop = 1'b0; start = 1'b0;
    chk("t4_busy", int'(busy), 0);
    chk("t4_sel", sel(), 0);
    chk("t4_av_done", int'({addr_valid, sweep_done}), 0);
    tick();
    chk("t4_start_ignored", int'(busy), 0);

    // Empty mask start, then a start while busy.
    do_start(8'h00, 1'b0, 1'b1, 3);
    for (int k = 0; k < 4; k++) begin
      chk("t5_zero_mask_busy", int'(busy), 0);
      tick();
    end
    do_start(8'hFF, 1'b0, 1'b1, 2);
    tick(); tick();
    do_start(8'h0F, 1'b1, 1'b0, 5);
    guard = 0;
    while (busy && guard < 60) begin
      tick();
      guard++;
    end
    chk("t5_sweep_ends", int'(busy), 0);

    // Reset in BLANK, then resume.
    do_start(8'hFF, 1'b0, 1'b0, 2);
    guard = 0;
    while (!(busy && !addr_valid) && guard < 60) begin
      tick();
      guard++;
    end
    chk("t6_reach_blank", int'(guard < 60), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_reset_outputs", int'({A2, A1, A0, addr_valid, busy, ch_step, sweep_done}), 0);
    do_start(8'h92, 1'b0, 1'b1, 1);
    chk("t6_resume_step", int'(ch_step), 1);
    chk("t6_resume_sel", sel(), 1);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 49) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 7))
        0:       mask = 8'h00;
        1:       mask = 8'h01 << $urandom_range(0, 7);
        default: mask = 8'($urandom);
      endcase
      dir        = 1'($urandom);
      mode_sweep = 1'($urandom);
      dwell      = DW'($urandom_range(0, 3));
      tick();
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
